// File: rtl/count_checker_pkg.sv
// count_checker_pkg
// Shared definitions for the count_checker slice: the FSM state encoding and
// the default bus widths and lock threshold.
package count_checker_pkg;

  localparam int DEF_WIDTH  = 4;
  localparam int DEF_ERR_W  = 8;
  localparam int DEF_LOCK_N = 2;

  typedef enum logic [1:0] {
    INIT    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_e;

endpackage

// File: rtl/count_checker_if.sv
// count_checker_if
// Bundles the monitored counter and the checker status outputs.
//   master : drives enable, count_in, clear_err; observes the status outputs
//   slave  : the checker itself
// Signals:
//   enable      enable of the monitored counter
//   count_in    monitored counter value (WIDTH)
//   clear_err   synchronous clear of err_sticky / err_count
//   locked      checker is in LOCKED
//   err_pulse   one-cycle sequence error flag (only while locked)
//   err_sticky  latched error flag
//   err_count   saturating error count (ERR_W)
//   wrap_pulse  one-cycle flag for an all-ones to zero step while locked
interface count_checker_if #(
  parameter int WIDTH = count_checker_pkg::DEF_WIDTH,
  parameter int ERR_W = count_checker_pkg::DEF_ERR_W
);

  logic             enable;
  logic [WIDTH-1:0] count_in;
  logic             clear_err;
  logic             locked;
  logic             err_pulse;
  logic             err_sticky;
  logic [ERR_W-1:0] err_count;
  logic             wrap_pulse;

  modport master (
    output enable, count_in, clear_err,
    input  locked, err_pulse, err_sticky, err_count, wrap_pulse
  );

  modport slave (
    input  enable, count_in, clear_err,
    output locked, err_pulse, err_sticky, err_count, wrap_pulse
  );

endinterface

// File: rtl/count_checker_sat.sv
// sat_counter
// Saturating event counter used for err_count.
// Ports:
//   clk    clock
//   reset  synchronous active-high reset
//   inc    count one event
//   clr    clear the count; an inc in the same cycle still counts, so the
//          result is 1 rather than 0
//   q      current count, holds at all-ones
module sat_counter
  import count_checker_pkg::*;
#(
  parameter int ERR_W = DEF_ERR_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [ERR_W-1:0] q
);

  logic [ERR_W-1:0] q_q;
  logic [ERR_W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end
    if (inc && (q_d != '1)) begin
      q_d = q_d + ERR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/count_checker.sv
// count_checker
// Watches a free-running counter and checks that each sample equals the
// previous sample plus the previous enable (mod 2^WIDTH). After LOCK_N
// consecutive good samples the checker locks; a mismatch while locked raises
// err_pulse and drops back to acquisition. All outputs are registered, so
// they show the result of a compare one cycle after the compare.
// Ports:
//   clk    clock, rising edge
//   reset  synchronous active-high reset
//   bus    count_checker_if slave (enable/count_in/clear_err in, status out)
//
// state   | meaning
// INIT    | after reset; no history yet, no compare
// ACQUIRE | counting consecutive good samples, errors not reported
// LOCKED  | sequence trusted; mismatches are reported
module count_checker
  import count_checker_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ERR_W  = DEF_ERR_W,
  parameter int LOCK_N = DEF_LOCK_N
) (
  input  logic                  clk,
  input  logic                  reset,
  count_checker_if.slave        bus
);

  localparam logic [3:0] LOCK_TGT = 4'(LOCK_N);

  state_e           state_q;
  logic [3:0]       good_cnt_q;
  logic [3:0]       good_cnt_d;
  logic [WIDTH-1:0] prev_q;
  logic             en_q;
  logic             locked_q;
  logic             err_pulse_q;
  logic             err_sticky_q;
  logic             wrap_pulse_q;
  logic [ERR_W-1:0] err_count;

  logic [WIDTH-1:0] expected;
  logic             match;
  logic             err_det;
  logic             wrap_det;

  always_comb begin
    expected   = prev_q + WIDTH'(en_q);
    match      = (bus.count_in == expected);
    err_det    = (state_q == LOCKED) && !match;
    wrap_det   = (state_q == LOCKED) && en_q && (prev_q == '1) &&
                 (bus.count_in == '0) && match;
    good_cnt_d = good_cnt_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= INIT;
      good_cnt_q   <= '0;
      prev_q       <= '0;
      en_q         <= 1'b0;
      locked_q     <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_sticky_q <= 1'b0;
      wrap_pulse_q <= 1'b0;
    end else begin
      prev_q       <= bus.count_in;
      en_q         <= bus.enable;
      err_pulse_q  <= err_det;
      wrap_pulse_q <= wrap_det;
      // a fresh error outranks a simultaneous clear
      err_sticky_q <= err_det | (err_sticky_q & ~bus.clear_err);

      case (state_q)
        INIT: begin
          state_q    <= ACQUIRE;
          good_cnt_q <= '0;
          locked_q   <= 1'b0;
        end
        ACQUIRE: begin
          if (match) begin
            good_cnt_q <= good_cnt_d;
            if (good_cnt_d == LOCK_TGT) begin
              state_q  <= LOCKED;
              locked_q <= 1'b1;
            end
          end else begin
            good_cnt_q <= '0;
          end
        end
        LOCKED: begin
          if (!match) begin
            state_q    <= ACQUIRE;
            good_cnt_q <= '0;
            locked_q   <= 1'b0;
          end
        end
        default: begin
          state_q    <= INIT;
          good_cnt_q <= '0;
          locked_q   <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(
    .ERR_W (ERR_W)
  ) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (err_det),
    .clr   (bus.clear_err),
    .q     (err_count)
  );

  assign bus.locked     = locked_q;
  assign bus.err_pulse  = err_pulse_q;
  assign bus.err_sticky = err_sticky_q;
  assign bus.err_count  = err_count;
  assign bus.wrap_pulse = wrap_pulse_q;

endmodule

// File: tb/tb_count_checker.sv
// tb_count_checker
// Directed bench for count_checker. Two instances share the stimulus: dut_a
// with the default 8-bit error counter and dut_b with a 2-bit counter to
// exercise saturation. Inputs change 1 ns after the rising edge and outputs
// are sampled there, so each check sees the result of the sample just driven.
module tb_count_checker;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  count_checker_if #(.WIDTH(4), .ERR_W(8)) ifa ();
  count_checker_if #(.WIDTH(4), .ERR_W(2)) ifb ();

  count_checker #(.WIDTH(4), .ERR_W(8), .LOCK_N(2)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa)
  );

  count_checker #(.WIDTH(4), .ERR_W(2), .LOCK_N(2)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic en, input logic [3:0] cnt, input logic clr);
    ifa.enable = en;  ifa.count_in = cnt;  ifa.clear_err = clr;
    ifb.enable = en;  ifb.count_in = cnt;  ifb.clear_err = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) drive(1'b1, 4'd7, 1'b1);
    n_tests++; if (ifa.locked !== 1'b0) begin n_fail++; $display("FAIL rst_locked: got %0b want 0", ifa.locked); end
    n_tests++; if (ifa.err_pulse !== 1'b0) begin n_fail++; $display("FAIL rst_err_pulse: got %0b want 0", ifa.err_pulse); end
    n_tests++; if (ifa.err_sticky !== 1'b0) begin n_fail++; $display("FAIL rst_err_sticky: got %0b want 0", ifa.err_sticky); end
    n_tests++; if (ifa.err_count !== 8'd0) begin n_fail++; $display("FAIL rst_err_count: got %0d want 0", ifa.err_count); end
    n_tests++; if (ifa.wrap_pulse !== 1'b0) begin n_fail++; $display("FAIL rst_wrap: got %0b want 0", ifa.wrap_pulse); end
    n_tests++; if (ifb.err_count !== 2'd0) begin n_fail++; $display("FAIL rst_err_count_b: got %0d want 0", ifb.err_count); end
  endtask

  task automatic test_lock();
    reset = 1'b0;
    drive(1'b1, 4'd0, 1'b0);
    n_tests++; if (ifa.locked !== 1'b0) begin n_fail++; $display("FAIL lock_init: got %0b want 0", ifa.locked); end
    drive(1'b1, 4'd1, 1'b0);
    n_tests++; if (ifa.locked !== 1'b0) begin n_fail++; $display("FAIL lock_one_good: got %0b want 0", ifa.locked); end
    drive(1'b1, 4'd2, 1'b0);
    n_tests++; if (ifa.locked !== 1'b1) begin n_fail++; $display("FAIL lock_two_good: got %0b want 1", ifa.locked); end
    n_tests++; if (ifa.err_pulse !== 1'b0) begin n_fail++; $display("FAIL lock_no_err: got %0b want 0", ifa.err_pulse); end
    drive(1'b1, 4'd3, 1'b0);
    n_tests++; if (ifa.locked !== 1'b1) begin n_fail++; $display("FAIL lock_stays: got %0b want 1", ifa.locked); end
  endtask

  task automatic test_hold();
    drive(1'b1, 4'd4, 1'b0);
    drive(1'b0, 4'd5, 1'b0);
    n_tests++; if (ifa.locked !== 1'b1) begin n_fail++; $display("FAIL hold_entry: got %0b want 1", ifa.locked); end
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 4'd5, 1'b0);
      n_tests++;
      if ({ifa.locked, ifa.err_pulse} !== 2'b10) begin
        n_fail++; $display("FAIL hold_cycle%0d: locked/err got %b want 10", i, {ifa.locked, ifa.err_pulse});
      end
    end
    drive(1'b0, 4'd6, 1'b0);
    n_tests++; if (ifa.err_pulse !== 1'b1) begin n_fail++; $display("FAIL hold_step_err: got %0b want 1", ifa.err_pulse); end
    n_tests++; if (ifa.err_count !== 8'd1) begin n_fail++; $display("FAIL hold_step_cnt: got %0d want 1", ifa.err_count); end
    n_tests++; if (ifa.locked !== 1'b0) begin n_fail++; $display("FAIL hold_step_unlock: got %0b want 0", ifa.locked); end
    drive(1'b1, 4'd6, 1'b0);
    n_tests++; if (ifa.err_pulse !== 1'b0) begin n_fail++; $display("FAIL err_one_cycle: got %0b want 0", ifa.err_pulse); end
    n_tests++; if (ifa.locked !== 1'b0) begin n_fail++; $display("FAIL relock_one_good: got %0b want 0", ifa.locked); end
    drive(1'b1, 4'd7, 1'b0);
    n_tests++; if (ifa.locked !== 1'b1) begin n_fail++; $display("FAIL relock_two_good: got %0b want 1", ifa.locked); end
  endtask

  task automatic test_clear();
    n_tests++; if (ifa.err_sticky !== 1'b1) begin n_fail++; $display("FAIL sticky_before_clr: got %0b want 1", ifa.err_sticky); end
    drive(1'b1, 4'd8, 1'b1);
    n_tests++; if (ifa.err_sticky !== 1'b0) begin n_fail++; $display("FAIL clr_sticky: got %0b want 0", ifa.err_sticky); end
    n_tests++; if (ifa.err_count !== 8'd0) begin n_fail++; $display("FAIL clr_count: got %0d want 0", ifa.err_count); end
    n_tests++; if (ifa.locked !== 1'b1) begin n_fail++; $display("FAIL clr_keeps_lock: got %0b want 1", ifa.locked); end
  endtask

  task automatic test_wrap();
    for (int v = 9; v <= 14; v++) drive(1'b1, 4'(v), 1'b0);
    drive(1'b1, 4'd15, 1'b0);
    n_tests++; if (ifa.wrap_pulse !== 1'b0) begin n_fail++; $display("FAIL wrap_early: got %0b want 0", ifa.wrap_pulse); end
    drive(1'b1, 4'd0, 1'b0);
    n_tests++; if (ifa.wrap_pulse !== 1'b1) begin n_fail++; $display("FAIL wrap_pulse: got %0b want 1", ifa.wrap_pulse); end
    n_tests++; if (ifa.err_pulse !== 1'b0) begin n_fail++; $display("FAIL wrap_no_err: got %0b want 0", ifa.err_pulse); end
    n_tests++; if (ifa.locked !== 1'b1) begin n_fail++; $display("FAIL wrap_locked: got %0b want 1", ifa.locked); end
    drive(1'b1, 4'd1, 1'b0);
    n_tests++; if (ifa.wrap_pulse !== 1'b0) begin n_fail++; $display("FAIL wrap_one_cycle: got %0b want 0", ifa.wrap_pulse); end
  endtask

  task automatic test_skip();
    drive(1'b1, 4'd2, 1'b0);
    drive(1'b1, 4'd3, 1'b0);
    drive(1'b1, 4'd5, 1'b0);
    n_tests++; if (ifa.err_pulse !== 1'b1) begin n_fail++; $display("FAIL skip_err: got %0b want 1", ifa.err_pulse); end
    n_tests++; if (ifa.err_sticky !== 1'b1) begin n_fail++; $display("FAIL skip_sticky: got %0b want 1", ifa.err_sticky); end
    n_tests++; if (ifa.err_count !== 8'd1) begin n_fail++; $display("FAIL skip_count: got %0d want 1", ifa.err_count); end
    drive(1'b1, 4'd6, 1'b0);
    n_tests++; if ({ifa.locked, ifa.err_pulse} !== 2'b00) begin n_fail++; $display("FAIL skip_reacq: locked/err got %b want 00", {ifa.locked, ifa.err_pulse}); end
    drive(1'b1, 4'd7, 1'b0);
    n_tests++; if (ifa.locked !== 1'b1) begin n_fail++; $display("FAIL skip_relock: got %0b want 1", ifa.locked); end
    n_tests++; if (ifa.err_sticky !== 1'b1) begin n_fail++; $display("FAIL skip_sticky_held: got %0b want 1", ifa.err_sticky); end
  endtask

  task automatic test_saturate(output logic [3:0] c_out);
    logic [3:0] c;
    logic [1:0] exp_b;
    reset = 1'b1;
    drive(1'b1, 4'd0, 1'b0);
    reset = 1'b0;
    c = 4'd0;
    drive(1'b1, c, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      c = c + 4'd1; drive(1'b1, c, 1'b0);
      c = c + 4'd1; drive(1'b1, c, 1'b0);
      n_tests++; if (ifa.locked !== 1'b1) begin n_fail++; $display("FAIL sat_lock%0d: got %0b want 1", i, ifa.locked); end
      c = c + 4'd2; drive(1'b1, c, 1'b0);
      exp_b = (i > 3) ? 2'd3 : 2'(i);
      n_tests++; if (ifb.err_count !== exp_b) begin n_fail++; $display("FAIL sat_count_b%0d: got %0d want %0d", i, ifb.err_count, exp_b); end
      n_tests++; if (ifa.err_count !== 8'(i)) begin n_fail++; $display("FAIL sat_count_a%0d: got %0d want %0d", i, ifa.err_count, i); end
    end
    c = c + 4'd1; drive(1'b1, c, 1'b0);
    c = c + 4'd1; drive(1'b1, c, 1'b0);
    c = c + 4'd2; drive(1'b1, c, 1'b1);
    n_tests++; if (ifb.err_count !== 2'd1) begin n_fail++; $display("FAIL clr_vs_err_b: got %0d want 1", ifb.err_count); end
    n_tests++; if (ifb.err_sticky !== 1'b1) begin n_fail++; $display("FAIL clr_vs_err_sticky: got %0b want 1", ifb.err_sticky); end
    n_tests++; if (ifa.err_count !== 8'd1) begin n_fail++; $display("FAIL clr_vs_err_a: got %0d want 1", ifa.err_count); end
    c_out = c;
  endtask

  task automatic test_reset_mid_lock(input logic [3:0] c_in);
    logic [3:0] c;
    c = c_in;
    c = c + 4'd1; drive(1'b1, c, 1'b0);
    c = c + 4'd1; drive(1'b1, c, 1'b0);
    n_tests++; if (ifa.locked !== 1'b1) begin n_fail++; $display("FAIL mid_pre_lock: got %0b want 1", ifa.locked); end
    reset = 1'b1;
    c = c + 4'd1; drive(1'b1, c, 1'b1);
    n_tests++;
    if ({ifa.locked, ifa.err_pulse, ifa.err_sticky, ifa.wrap_pulse} !== 4'b0000 || ifa.err_count !== 8'd0) begin
      n_fail++; $display("FAIL mid_reset_outs: l/e/s/w got %b cnt %0d want 0000 cnt 0",
                         {ifa.locked, ifa.err_pulse, ifa.err_sticky, ifa.wrap_pulse}, ifa.err_count);
    end
    reset = 1'b0;
    drive(1'b1, 4'd5, 1'b0);
    n_tests++; if (ifa.locked !== 1'b0) begin n_fail++; $display("FAIL mid_init: got %0b want 0", ifa.locked); end
    drive(1'b1, 4'd6, 1'b0);
    n_tests++; if (ifa.locked !== 1'b0) begin n_fail++; $display("FAIL mid_one_good: got %0b want 0", ifa.locked); end
    drive(1'b1, 4'd8, 1'b0);
    n_tests++; if (ifa.err_pulse !== 1'b0) begin n_fail++; $display("FAIL acq_no_err: got %0b want 0", ifa.err_pulse); end
    drive(1'b1, 4'd9, 1'b0);
    n_tests++; if (ifa.locked !== 1'b0) begin n_fail++; $display("FAIL acq_good_cleared: got %0b want 0", ifa.locked); end
    drive(1'b1, 4'd10, 1'b0);
    n_tests++; if (ifa.locked !== 1'b1) begin n_fail++; $display("FAIL mid_relock: got %0b want 1", ifa.locked); end
  endtask

  initial begin
    logic [3:0] c_last;
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    ifa.enable = 1'b0; ifa.count_in = 4'd0; ifa.clear_err = 1'b0;
    ifb.enable = 1'b0; ifb.count_in = 4'd0; ifb.clear_err = 1'b0;
    test_reset();
    test_lock();
    test_hold();
    test_clear();
    test_wrap();
    test_skip();
    test_saturate(c_last);
    test_reset_mid_lock(c_last);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
